mips_store_buffer: RTL and testbench
====================================

// Module: mips_store_buffer
// PURPOSE
// - Posted-write buffer between the core data port (data_addr/data_out/data_rd_wr/data_in) and a
//   slower data memory with req/ack write handshake. Core stores retire in one cycle into a FIFO,
//   drained in order to memory; loads read memory combinationally, optionally bypassing from FIFO.
// - Core has no stall input: buffer never back-pressures; overflow is flagged, not stalled.
// PARAMETERS
// - DEPTH   4   FIFO entries; power of two, >=2
// - ADDR_W  32  address width (word address = addr[ADDR_W-1:2])
// PORTS
// - clk          in   1       clock, all state on rising edge
// - reset        in   1       synchronous, active-high
// - core_rd_wr   in   1       1 = read/idle, 0 = store this cycle
// - core_addr    in   ADDR_W  load/store byte address
// - core_wdata   in   32      store data
// - core_rdata   out  32      load data (combinational)
// - mem_rd_addr  out  ADDR_W  memory read address (= core_addr)
// - mem_rd_data  in   32      memory async read data
// - mem_req      out  1       write request, held until ack
// - mem_addr     out  ADDR_W  write address (head entry)
// - mem_wdata    out  32      write data (head entry)
// - mem_ack      in   1       write accepted at this edge
// - count        out  $clog2(DEPTH)+1  valid entries
// - full / empty out  1       count==DEPTH / count==0
// - overflow     out  1       sticky: a store was dropped
// BEHAVIOUR
// - Reset: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, mem_req=0, overflow=0, FSM=IDLE; entry
//   contents undefined. Reset mid-handshake drops mem_req next cycle; head entry is discarded.
// - Enqueue: edge with reset=0 and core_rd_wr=0 writes {core_addr,core_wdata} at wr_ptr, wr_ptr++
//   (mod DEPTH, wraps), count++. Store visible to memory side no earlier than next cycle.
// - Drain FSM: IDLE: if count!=0 -> BUSY (mem_req=1 from next cycle). BUSY: mem_req=1,
//   mem_addr/mem_wdata = head entry, stable while BUSY. mem_ack=1 at edge -> pop (rd_ptr++,
//   count--); if count after pop >0 stay BUSY (back-to-back, next head next cycle) else IDLE.
//   mem_ack ignored in IDLE. Latency store->mem_req min 2 cycles from empty.
// - mem_req is a registered output; mem_addr/mem_wdata driven from FIFO head register array.
// - Simultaneous enqueue+pop: count unchanged; allowed when full (pop frees slot same edge, no
//   overflow). Enqueue while full with no pop at that edge: store dropped, overflow<=1, state
//   otherwise unchanged.
// - Ordering: strict FIFO; no coalescing of same-address stores.
// - Loads: mem_rd_addr = core_addr always; core_rdata per CONFIGURATION.
// - Address match uses addr[ADDR_W-1:2] only; addr[1:0] ignored.
// CONFIGURATION
// - STORE_BUF_FWD_EN defined: core_rdata = data of youngest valid entry whose word address
//   matches core_addr (head entry in BUSY counts until popped); no match -> mem_rd_data.
//   Forwarding is combinational on current buffer state, same cycle as the load.
// - Not defined: core_rdata = mem_rd_data; loads may return stale data for buffered stores;
//   no compare logic synthesised.
// TESTING
// - Reset, store 0x1234 @0x10, mem_ack tied 1 -> mem_req high 2 cycles later with addr 0x10,
//   data 0x1234, one cycle; count 1->0; empty=1.
// - 4 stores (0x0,0x4,0x8,0xC; data 1..4), mem_ack=0 -> full=1, count=4; 5th store ->
//   overflow=1, count=4; then ack each cycle -> memory writes 1,2,3,4 in order, 5th never appears.
// - Full buffer, store on same edge as mem_ack -> overflow stays 0, count stays 4, new entry
//   drained last (pointer wrap).
// - FWD_EN: stores 0xA@0x20 then 0xB@0x20, ack held 0, load 0x22 -> core_rdata=0xB;
//   load 0x24 -> mem_rd_data. Without macro: load 0x20 -> mem_rd_data.
// - mem_ack asserted in IDLE -> no pop, count unchanged.
// - Reset asserted while BUSY with 3 entries -> next cycle mem_req=0, count=0, overflow=0.

Source files
------------

// File: rtl/mips_store_buffer.sv
// mips_store_buffer: posted-write buffer between the core data port and a slower data memory.
// Core stores retire in one cycle into a DEPTH-entry FIFO that drains in order through a
// req/ack write handshake. Loads read memory combinationally; the buffer never stalls the
// core, so a store arriving while full (with no pop on the same edge) is dropped and flagged.
//
// Optional feature macro: STORE_BUF_FWD_EN
//   defined   -> loads return the youngest buffered store to the same word address, else memory
//   undefined -> loads always return mem_rd_data (no compare logic)
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   core_rd_wr              1 = read/idle, 0 = store this cycle
//   core_addr, core_wdata   core byte address and store data
//   core_rdata              load data (combinational)
//   mem_rd_addr, mem_rd_data  memory async read port (address mirrors core_addr)
//   mem_req, mem_ack        write handshake; mem_req registered and held until ack
//   mem_addr, mem_wdata     head-of-FIFO write address/data
//   count, full, empty      occupancy status
//   overflow                sticky flag: a store was dropped
module mips_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       core_rd_wr,
  input  logic [ADDR_W-1:0]          core_addr,
  input  logic [31:0]                core_wdata,
  output logic [31:0]                core_rdata,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic [31:0]                mem_rd_data,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ack,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Entry storage: no reset, contents are only meaningful between rd_ptr and wr_ptr.
  entry_t buf_q [DEPTH];

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               req_q, req_d;

  logic               full_c;
  logic               store_c;
  logic               pop_c;
  logic               enq_c;

  // Handshake and enqueue qualification for the coming edge.
  always_comb begin
    full_c  = (count_q == CNT_W'(DEPTH));
    store_c = ~core_rd_wr;
    pop_c   = (state_q == BUSY) && mem_ack;
    // A pop on the same edge frees the slot, so a store to a full buffer still lands.
    enq_c   = store_c && (~full_c || pop_c);
  end

  // Next-state: pointers, occupancy, overflow flag and drain FSM.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    req_d    = 1'b0;

    if (enq_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({enq_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (store_c && full_c && ~pop_c) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // Decision uses the registered count, so a fresh store is seen one cycle later.
        if (count_q != '0) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (pop_c && (count_d == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d == BUSY);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      req_q    <= req_d;
    end
  end

  // Entry write port.
  always_ff @(posedge clk) begin
    if (!reset && enq_c) begin
      buf_q[wr_ptr_q] <= '{addr: core_addr, data: core_wdata};
    end
  end

  // Load data path.
`ifdef STORE_BUF_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    core_rdata = mem_rd_data;
    fwd_idx    = rd_ptr_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (buf_q[fwd_idx].addr[ADDR_W-1:2] == core_addr[ADDR_W-1:2])) begin
        core_rdata = buf_q[fwd_idx].data;
      end
    end
  end
`else
  assign core_rdata = mem_rd_data;
`endif

  assign mem_rd_addr = core_addr;
  assign mem_req     = req_q;
  assign mem_addr    = buf_q[rd_ptr_q].addr;
  assign mem_wdata   = buf_q[rd_ptr_q].data;
  assign count       = count_q;
  assign full        = full_c;
  assign empty       = (count_q == '0);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mips_store_buffer.sv
module tb_mips_store_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        rd_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    int          exp_count;
    logic        exp_req;
    logic        exp_ovf;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        core_rd_wr;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  int checks;
  int failures;

  // Reference model state; m_q doubles as the scoreboard of expected memory writes.
  ent_t m_q[$];
  logic m_busy;
  logic m_ovf;

  vec_t vecs[10];

  mips_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_rd_wr (core_rd_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory read data is a recognisable function of the read address.
  assign mem_rd_data = {16'hC0DE, mem_rd_addr[15:0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs against the model, clock, advance model.
  task automatic step(input logic rst_v, input logic rdwr_v, input logic [31:0] a_v,
                      input logic [31:0] d_v, input logic ack_v);
    logic        pop;
    logic        old_busy;
    int          old_sz;
    logic [31:0] exp_rd;
    ent_t        e;
    reset      = rst_v;
    core_rd_wr = rdwr_v;
    core_addr  = a_v;
    core_wdata = d_v;
    mem_ack    = ack_v;
    #1;
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    chk("count", 32'(count), 32'(m_q.size()));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("mem_rd_addr", mem_rd_addr, a_v);
    exp_rd = {16'hC0DE, a_v[15:0]};
`ifdef STORE_BUF_FWD_EN
    foreach (m_q[k]) begin
      if (m_q[k].addr[31:2] == a_v[31:2]) exp_rd = m_q[k].data;
    end
`endif
    chk("core_rdata", core_rdata, exp_rd);

    old_busy = m_busy;
    old_sz   = m_q.size();
    pop      = !rst_v && m_busy && ack_v;
    if (pop) begin
      e = m_q.pop_front();
      chk("wr_addr", mem_addr, e.addr);
      chk("wr_data", mem_wdata, e.data);
    end
    if (rst_v) begin
      m_q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (!rdwr_v) begin
        if (m_q.size() < DEPTH) m_q.push_back('{addr: a_v, data: d_v});
        else m_ovf = 1'b1;
      end
      m_busy = old_busy ? (m_q.size() > 0) : (old_sz != 0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_busy   = 1'b0;
    m_ovf    = 1'b0;

    // Four stores with no ack, a dropped fifth, then one-per-cycle drain.
    vecs[0] = '{1'b0, 32'h0000_0000, 32'd1, 1'b0, 1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'd2, 1'b0, 2, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0008, 32'd3, 1'b0, 3, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_000C, 32'd4, 1'b0, 4, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0010, 32'd5, 1'b0, 4, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0040, 32'd0, 1'b1, 3, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0044, 32'd0, 1'b1, 2, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0048, 32'd0, 1'b1, 1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_004C, 32'd0, 1'b1, 0, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 32'h0000_0050, 32'd0, 1'b0, 0, 1'b0, 1'b1};

    reset      = 1'b1;
    core_rd_wr = 1'b1;
    core_addr  = '0;
    core_wdata = '0;
    mem_ack    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);

    // Single store with ack tied high; an ack while IDLE must not pop.
    step(1'b0, 1'b0, 32'h10, 32'h1234, 1'b1);
    chk("t1_req_c1", 32'(mem_req), 32'd0);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    chk("idle_ack_count", 32'(count), 32'd1);
    chk("t1_req_c2", 32'(mem_req), 32'd1);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_data", mem_wdata, 32'h1234);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    chk("t1_req_c3", 32'(mem_req), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);

    // Table-driven fill/overflow/drain.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, vecs[i].rd_wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
    end

    // Full buffer: store on the same edge as an ack lands without overflow and wraps.
    step(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    chk("rst_clears_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    step(1'b0, 1'b0, 32'h200, 32'h55, 1'b1);
    chk("simul_ovf", 32'(overflow), 32'd0);
    chk("simul_count", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    chk("wrap_last_addr", mem_addr, 32'h200);
    chk("wrap_last_data", mem_wdata, 32'h55);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

    // Load forwarding from two stores to the same word.
    step(1'b0, 1'b0, 32'h20, 32'hA, 1'b0);
    step(1'b0, 1'b0, 32'h20, 32'hB, 1'b0);
    step(1'b0, 1'b1, 32'h22, 32'h0, 1'b0);
    #1;
`ifdef STORE_BUF_FWD_EN
    chk("fwd_hit", core_rdata, 32'h0000_000B);
`else
    chk("fwd_hit", core_rdata, 32'hC0DE_0022);
`endif
    core_addr = 32'h24;
    #1;
    chk("fwd_miss", core_rdata, 32'hC0DE_0024);
    @(negedge clk);
    step(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);

    // Reset while BUSY with three entries and overflow set.
    step(1'b0, 1'b0, 32'h300, 32'h1, 1'b0);
    step(1'b0, 1'b0, 32'h304, 32'h2, 1'b0);
    step(1'b0, 1'b0, 32'h308, 32'h3, 1'b0);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 32'h30C, 32'h4, 1'b1);
    chk("busy_rst_req", 32'(mem_req), 32'd0);
    chk("busy_rst_count", 32'(count), 32'd0);
    chk("busy_rst_ovf", 32'(overflow), 32'd0);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
